// File: rtl/geofence_poly.sv
// Point-in-convex-polygon engine: loads a target and NV vertices, sorts the vertices angularly, then sign-tests each edge.
// Optional macro GEO_AREA_EN adds the area2 output (twice the polygon area).
module geofence_poly #(
  parameter int unsigned NV = 6,
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          in_ready,
  output logic          valid,
  output logic          is_inside
`ifdef GEO_AREA_EN
  ,
  output logic [2*CW+4:0] area2
`endif
);

  localparam int unsigned DW = CW + 1;
  localparam int unsigned PW = 2 * CW + 3;
  localparam int unsigned IW = $clog2(NV + 1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_CHECK, S_DONE} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] px_q [0:NV];
  logic [CW-1:0] px_d [0:NV];
  logic [CW-1:0] py_q [0:NV];
  logic [CW-1:0] py_d [0:NV];
  logic [IW-1:0] ld_q, ld_d, outer_q, outer_d, j_q, j_d, i_q, i_d;
  logic          neg_q, neg_d, pos_q, pos_d;
  logic          valid_q, valid_d, in_ready_q, in_ready_d, inside_q, inside_d;

  function automatic logic signed [DW-1:0] ext(input logic [CW-1:0] a);
    return $signed({1'b0, a});
  endfunction

  function automatic logic signed [DW-1:0] sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return ext(a) - ext(b);
  endfunction

  // Full-width 2-D cross product; operand ranges guarantee no overflow in PW bits.
  function automatic logic signed [PW-1:0] cross2(input logic signed [DW-1:0] ax,
                                                  input logic signed [DW-1:0] ay,
                                                  input logic signed [DW-1:0] bx,
                                                  input logic signed [DW-1:0] by);
    logic signed [PW-1:0] p0, p1;
    p0 = PW'(ax) * PW'(by);
    p1 = PW'(ay) * PW'(bx);
    return p0 - p1;
  endfunction

  logic [IW-1:0]        jn_c, in_c;
  logic signed [PW-1:0] sort_x_c, chk_x_c;
  logic                 swap_c, adv_c, sort_done_c, chk_last_c, accept_c, load_last_c;
  logic                 neg_now_c, pos_now_c;

  assign jn_c = j_q + IW'(1);
  assign in_c = (i_q == IW'(NV)) ? IW'(1) : i_q + IW'(1);

  assign sort_x_c = cross2(sub(px_q[j_q], px_q[1]), sub(py_q[j_q], py_q[1]),
                           sub(px_q[jn_c], px_q[1]), sub(py_q[jn_c], py_q[1]));
  assign chk_x_c  = cross2(sub(px_q[i_q], px_q[0]), sub(py_q[i_q], py_q[0]),
                           sub(px_q[in_c], px_q[i_q]), sub(py_q[in_c], py_q[i_q]));

  assign swap_c      = !sort_x_c[PW-1];
  assign adv_c       = !swap_c || (j_q == IW'(2));
  assign sort_done_c = adv_c && (outer_q == IW'(NV - 1));
  assign chk_last_c  = (i_q == IW'(NV));
  assign accept_c    = in_valid && in_ready_q;
  assign load_last_c = accept_c && (ld_q == IW'(NV));
  assign neg_now_c   = chk_x_c[PW-1];
  assign pos_now_c   = !chk_x_c[PW-1] && (chk_x_c != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_last_c) state_d = S_SORT;
      S_SORT:  if (sort_done_c) state_d = S_CHECK;
      S_CHECK: if (chk_last_c)  state_d = S_DONE;
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    px_d       = px_q;
    py_d       = py_q;
    ld_d       = ld_q;
    outer_d    = outer_q;
    j_d        = j_q;
    i_d        = i_q;
    neg_d      = neg_q;
    pos_d      = pos_q;
    inside_d   = inside_q;
    in_ready_d = (state_d == S_LOAD);
    valid_d    = (state_d == S_DONE);
    case (state_q)
      S_LOAD: begin
        if (accept_c) begin
          px_d[ld_q] = X;
          py_d[ld_q] = Y;
          ld_d       = ld_q + IW'(1);
          if (load_last_c) begin
            ld_d    = '0;
            outer_d = IW'(2);
            j_d     = IW'(2);
          end
        end
      end
      S_SORT: begin
        if (swap_c) begin
          px_d[j_q]  = px_q[jn_c];
          px_d[jn_c] = px_q[j_q];
          py_d[j_q]  = py_q[jn_c];
          py_d[jn_c] = py_q[j_q];
        end
        // Advancing restarts the insertion at the new outer index.
        if (adv_c) begin
          outer_d = outer_q + IW'(1);
          j_d     = outer_q + IW'(1);
        end else begin
          j_d = j_q - IW'(1);
        end
        if (sort_done_c) i_d = IW'(1);
      end
      S_CHECK: begin
        neg_d = neg_q | neg_now_c;
        pos_d = pos_q | pos_now_c;
        i_d   = in_c;
        if (chk_last_c) inside_d = !(neg_d & pos_d);
      end
      S_DONE: begin
        neg_d = 1'b0;
        pos_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q       <= '{default: '0};
      py_q       <= '{default: '0};
      ld_q       <= '0;
      outer_q    <= '0;
      j_q        <= '0;
      i_q        <= '0;
      neg_q      <= 1'b0;
      pos_q      <= 1'b0;
      inside_q   <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      px_q       <= px_d;
      py_q       <= py_d;
      ld_q       <= ld_d;
      outer_q    <= outer_d;
      j_q        <= j_d;
      i_q        <= i_d;
      neg_q      <= neg_d;
      pos_q      <= pos_d;
      inside_q   <= inside_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign valid     = valid_q;
  assign is_inside = inside_q;

`ifdef GEO_AREA_EN
  localparam int unsigned AW = 2 * CW + 6;
  localparam int unsigned OW = 2 * CW + 5;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [OW-1:0]        area_q, area_d;
  logic signed [PW-1:0] term_c;

  assign term_c = cross2(ext(px_q[i_q]), ext(py_q[i_q]), ext(px_q[in_c]), ext(py_q[in_c]));

  // Shoelace sum over the sorted ring, magnitude latched with the result.
  always_comb begin
    acc_d  = acc_q;
    area_d = area_q;
    if (state_q == S_CHECK) begin
      acc_d = acc_q + AW'(term_c);
      if (chk_last_c) area_d = OW'(acc_d[AW-1] ? -acc_d : acc_d);
    end else if (state_q == S_DONE) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      area_q <= '0;
    end else begin
      acc_q  <= acc_d;
      area_q <= area_d;
    end
  end

  assign area2 = area_q;
`endif

endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench for geofence_poly: NV=4 square and NV=6 hexagon instances, gaps, back-to-back and mid-sort reset.
// Checks area2 as well when built with GEO_AREA_EN.
module tb_geofence_poly;

  logic       clk;
  logic       rst;
  logic       v4, v6;
  logic [9:0] X, Y;
  logic       r4, val4, in4, r6, val6, in6;
`ifdef GEO_AREA_EN
  logic [24:0] a4, a6;
`endif

  int errs   = 0;
  int checks = 0;

  int vx4 [4] = '{0, 10, 10, 0};
  int vy4 [4] = '{0, 10, 0, 10};
  int vx6 [6] = '{200, 50, 200, 100, 250, 100};
  int vy6 [6] = '{250, 150, 50, 250, 150, 50};

  geofence_poly #(.NV(4), .CW(10)) u_dut4 (
    .clk(clk), .reset(rst), .in_valid(v4), .X(X), .Y(Y),
    .in_ready(r4), .valid(val4), .is_inside(in4)
`ifdef GEO_AREA_EN
    , .area2(a4)
`endif
  );

  geofence_poly #(.NV(6), .CW(10)) u_dut6 (
    .clk(clk), .reset(rst), .in_valid(v6), .X(X), .Y(Y),
    .in_ready(r6), .valid(val6), .is_inside(in6)
`ifdef GEO_AREA_EN
    , .area2(a6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic cur_rdy(input int sel);
    return (sel == 4) ? r4 : r6;
  endfunction

  function automatic logic cur_val(input int sel);
    return (sel == 4) ? val4 : val6;
  endfunction

  function automatic logic cur_in(input int sel);
    return (sel == 4) ? in4 : in6;
  endfunction

  function automatic int bound(input int n);
    return (n - 1) * (n - 2) / 2 + (n - 2) + n + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input int sel, input int tx, input int ty, input bit gaps, input string tag);
    int wx, wy, guard;
    for (int k = 0; k <= sel; k++) begin
      if (k == 0) begin
        wx = tx; wy = ty;
      end else if (sel == 4) begin
        wx = vx4[k-1]; wy = vy4[k-1];
      end else begin
        wx = vx6[k-1]; wy = vy6[k-1];
      end
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      guard = 0;
      while (cur_rdy(sel) !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check({tag, "_rdy_wait"}, 0, 1);
      X = 10'(wx);
      Y = 10'(wy);
      if (sel == 4) v4 = 1'b1; else v6 = 1'b1;
      tick();
      v4 = 1'b0;
      v6 = 1'b0;
    end
  endtask

  task automatic wait_result(input int sel, input bit exp_in, input int exp_area, input string tag);
    int cnt;
    bit got;
    bit rdy_ok;
    logic held;
    cnt = 0; got = 0; rdy_ok = 1;
    while (!got && cnt < 40) begin
      if (cur_rdy(sel) !== 1'b0) rdy_ok = 0;
      if (cur_val(sel) === 1'b1) got = 1;
      else begin
        tick();
        cnt++;
      end
    end
    check({tag, "_valid"}, 32'(got), 1);
    check({tag, "_within_bound"}, 32'(cnt <= bound(sel)), 1);
    check({tag, "_rdy_low"}, 32'(rdy_ok), 1);
    check({tag, "_inside"}, 32'(cur_in(sel)), 32'(exp_in));
`ifdef GEO_AREA_EN
    check({tag, "_area2"}, (sel == 4) ? 32'(a4) : 32'(a6), 32'(exp_area));
`endif
    $display("%s: latency %0d cycles, area2 reference %0d", tag, cnt, exp_area);
    held = cur_in(sel);
    tick();
    check({tag, "_single_pulse"}, 32'(cur_val(sel)), 0);
    check({tag, "_rdy_back"}, 32'(cur_rdy(sel)), 1);
    check({tag, "_hold"}, 32'(cur_in(sel)), 32'(held));
  endtask

  task automatic run(input int sel, input int tx, input int ty, input bit gaps,
                     input bit exp_in, input int exp_area, input string tag);
    send_words(sel, tx, ty, gaps, tag);
    wait_result(sel, exp_in, exp_area, tag);
  endtask

  initial begin
    bit seen;
    bit rdy_stay;
    rst = 1'b1; v4 = 1'b0; v6 = 1'b0; X = '0; Y = '0;
    repeat (3) tick();
    check("rst_valid4", 32'(val4), 0);
    check("rst_rdy4", 32'(r4), 1);
    check("rst_inside4", 32'(in4), 0);
    check("rst_valid6", 32'(val6), 0);
    check("rst_rdy6", 32'(r6), 1);
    check("rst_inside6", 32'(in6), 0);
    rst = 1'b0;
    tick();

    run(4, 5, 5, 0, 1, 200, "sq_center");
    run(4, 15, 5, 0, 0, 200, "sq_outside");
    run(4, 10, 5, 0, 1, 200, "sq_on_edge");
    run(4, 5, 5, 1, 1, 200, "sq_gaps_in");
    run(4, 15, 5, 1, 0, 200, "sq_gaps_out");

    run(6, 150, 150, 0, 1, 60000, "hex_center");
    run(6, 300, 150, 0, 0, 60000, "hex_b2b_out");
    run(6, 150, 150, 0, 1, 60000, "hex_center2");

    // Abort a frame while the vertex sort is in progress.
    send_words(6, 300, 150, 0, "hex_abort");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_valid", 32'(val6), 0);
    check("abort_rdy", 32'(r6), 1);
    check("abort_inside", 32'(in6), 0);
    rst = 1'b0;
    seen = 0; rdy_stay = 1;
    repeat (30) begin
      tick();
      if (val6 !== 1'b0) seen = 1;
      if (r6 !== 1'b1) rdy_stay = 1'b0;
    end
    check("abort_no_valid", 32'(seen), 0);
    check("abort_rdy_stays", 32'(rdy_stay), 1);
    run(6, 150, 150, 0, 1, 60000, "hex_after_abort");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
